// File: rtl/serial_bridge_pkg.sv
// Shared widths and serializer state encoding for the serial word bridge.
package serial_bridge_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTES_PER_WORD = 4;

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_e;

   // Byte lane idx of a word, lane 0 being the least significant byte.
   function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                   input logic [1:0]        idx);
      return w[BYTE_W*idx +: BYTE_W];
   endfunction

endpackage

// File: rtl/serial_word_bridge_fifo.sv
// Small synchronous word FIFO with full/empty flags; head reads as zero when empty.
module word_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: empty masks the head and pointers restart at zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/serial_word_bridge.sv
// Packs host bytes into 32-bit words for the feeder and serializes feeder words
// back into bytes, little-endian in both directions.
module serial_word_bridge
   import serial_bridge_pkg::*;
#(
   parameter int unsigned UP_FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BYTE_W-1:0]    byteIn_put,
   input  logic                 EN_byteIn_put,
   output logic                 RDY_byteIn_put,
   output logic [BYTE_W-1:0]    byteOut_get,
   input  logic                 EN_byteOut_get,
   output logic                 RDY_byteOut_get,
   output logic [WORD_W-1:0]    msgToFeeder_data,
   output logic                 msgToFeeder_en,
   input  logic                 msgToFeeder_rdy,
   input  logic [WORD_W-1:0]    msgFromFeeder_data,
   output logic                 msgFromFeeder_en,
   input  logic                 msgFromFeeder_rdy,
   output logic                 errOverflow,
   output logic [CNT_WIDTH-1:0] wordsUp,
   output logic [CNT_WIDTH-1:0] wordsDown
);

   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   logic [1:0]                 pk_cnt_q, pk_cnt_d;
   logic [WORD_W-BYTE_W-1:0]   pk_part_q, pk_part_d;
   logic                       err_q, err_d;
   logic                       fifo_push, fifo_full, fifo_empty;
   logic [WORD_W-1:0]          fifo_head;
   logic                       up_en, dn_en;
   ser_state_e                 ser_state_q, ser_state_d;
   logic [1:0]                 ser_idx_q, ser_idx_d;
   logic [WORD_W-1:0]          ser_word_q, ser_word_d;
   logic [CNT_WIDTH-1:0]       up_cnt_q, up_cnt_d;
   logic [CNT_WIDTH-1:0]       dn_cnt_q, dn_cnt_d;

   // Ready depends on registered state only, never on an input.
   assign RDY_byteIn_put  = (pk_cnt_q != LAST_BYTE) || !fifo_full;
   assign RDY_byteOut_get = (ser_state_q == SER_SEND);
   assign byteOut_get     = RDY_byteOut_get ? word_byte(ser_word_q, ser_idx_q) : '0;

   assign up_en            = RST && !fifo_empty && msgToFeeder_rdy;
   assign msgToFeeder_en   = up_en;
   assign msgToFeeder_data = fifo_head;
   assign msgFromFeeder_en = dn_en;
   assign errOverflow      = err_q;
   assign wordsUp          = up_cnt_q;
   assign wordsDown        = dn_cnt_q;

   word_fifo #(
      .DEPTH (UP_FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_up_fifo (
      .clk       (CLK),
      .rst_n     (RST),
      .push      (fifo_push),
      .push_data ({byteIn_put, pk_part_q}),
      .pop       (up_en),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      pk_cnt_d  = pk_cnt_q;
      pk_part_d = pk_part_q;
      err_d     = err_q;
      fifo_push = 1'b0;
      if (EN_byteIn_put) begin
         if (!RDY_byteIn_put) begin
            err_d = 1'b1;
         end else if (pk_cnt_q == LAST_BYTE) begin
            fifo_push = 1'b1;
            pk_cnt_d  = '0;
         end else begin
            pk_part_d[BYTE_W*pk_cnt_q +: BYTE_W] = byteIn_put;
            pk_cnt_d = pk_cnt_q + 2'd1;
         end
      end
   end

   always_comb begin
      ser_state_d = ser_state_q;
      ser_idx_d   = ser_idx_q;
      ser_word_d  = ser_word_q;
      dn_en       = 1'b0;
      case (ser_state_q)
         SER_IDLE: begin
            dn_en = RST && msgFromFeeder_rdy;
            if (dn_en) begin
               ser_word_d  = msgFromFeeder_data;
               ser_idx_d   = '0;
               ser_state_d = SER_SEND;
            end
         end
         SER_SEND: begin
            if (EN_byteOut_get) begin
               ser_idx_d = ser_idx_q + 2'd1;
               if (ser_idx_q == LAST_BYTE) begin
                  ser_state_d = SER_IDLE;
               end
            end
         end
         default: ser_state_d = SER_IDLE;
      endcase
   end

   always_comb begin
      up_cnt_d = (up_en && (up_cnt_q != '1)) ? up_cnt_q + 1'b1 : up_cnt_q;
      dn_cnt_d = (dn_en && (dn_cnt_q != '1)) ? dn_cnt_q + 1'b1 : dn_cnt_q;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         pk_cnt_q    <= '0;
         pk_part_q   <= '0;
         err_q       <= 1'b0;
         ser_state_q <= SER_IDLE;
         ser_idx_q   <= '0;
         ser_word_q  <= '0;
         up_cnt_q    <= '0;
         dn_cnt_q    <= '0;
      end else begin
         pk_cnt_q    <= pk_cnt_d;
         pk_part_q   <= pk_part_d;
         err_q       <= err_d;
         ser_state_q <= ser_state_d;
         ser_idx_q   <= ser_idx_d;
         ser_word_q  <= ser_word_d;
         up_cnt_q    <= up_cnt_d;
         dn_cnt_q    <= dn_cnt_d;
      end
   end

endmodule

// File: tb/tb_serial_word_bridge.sv
// Directed bench for serial_word_bridge; a second instance with 2-bit counters
// shares the stimulus to exercise counter saturation.
module tb_serial_word_bridge;

   logic        CLK;
   logic        RST;
   logic [7:0]  byteIn_put;
   logic        EN_byteIn_put;
   logic        RDY_byteIn_put;
   logic [7:0]  byteOut_get;
   logic        EN_byteOut_get;
   logic        RDY_byteOut_get;
   logic [31:0] msgToFeeder_data;
   logic        msgToFeeder_en;
   logic        msgToFeeder_rdy;
   logic [31:0] msgFromFeeder_data;
   logic        msgFromFeeder_en;
   logic        msgFromFeeder_rdy;
   logic        errOverflow;
   logic [15:0] wordsUp, wordsDown;

   logic        d2_rdy_in, d2_rdy_out, d2_up_en, d2_dn_en, d2_err;
   logic [7:0]  d2_byte_out;
   logic [31:0] d2_up_data;
   logic [1:0]  d2_words_up, d2_words_down;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [31:0] up_q [$];
   int unsigned dn_seen = 0;

   serial_word_bridge #(.UP_FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
      .CLK(CLK), .RST(RST),
      .byteIn_put(byteIn_put), .EN_byteIn_put(EN_byteIn_put), .RDY_byteIn_put(RDY_byteIn_put),
      .byteOut_get(byteOut_get), .EN_byteOut_get(EN_byteOut_get), .RDY_byteOut_get(RDY_byteOut_get),
      .msgToFeeder_data(msgToFeeder_data), .msgToFeeder_en(msgToFeeder_en),
      .msgToFeeder_rdy(msgToFeeder_rdy),
      .msgFromFeeder_data(msgFromFeeder_data), .msgFromFeeder_en(msgFromFeeder_en),
      .msgFromFeeder_rdy(msgFromFeeder_rdy),
      .errOverflow(errOverflow), .wordsUp(wordsUp), .wordsDown(wordsDown)
   );

   serial_word_bridge #(.UP_FIFO_DEPTH(4), .CNT_WIDTH(2)) dut2 (
      .CLK(CLK), .RST(RST),
      .byteIn_put(byteIn_put), .EN_byteIn_put(EN_byteIn_put), .RDY_byteIn_put(d2_rdy_in),
      .byteOut_get(d2_byte_out), .EN_byteOut_get(EN_byteOut_get), .RDY_byteOut_get(d2_rdy_out),
      .msgToFeeder_data(d2_up_data), .msgToFeeder_en(d2_up_en),
      .msgToFeeder_rdy(msgToFeeder_rdy),
      .msgFromFeeder_data(msgFromFeeder_data), .msgFromFeeder_en(d2_dn_en),
      .msgFromFeeder_rdy(msgFromFeeder_rdy),
      .errOverflow(d2_err), .wordsUp(d2_words_up), .wordsDown(d2_words_down)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Feeder-side transfers are observed mid-cycle, one record per enabled cycle.
   always @(negedge CLK) begin
      if (msgToFeeder_en) up_q.push_back(msgToFeeder_data);
      if (msgFromFeeder_en) dn_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic put(input logic [7:0] b);
      byteIn_put    = b;
      EN_byteIn_put = 1'b1;
      tick();
      EN_byteIn_put = 1'b0;
   endtask

   task automatic get();
      EN_byteOut_get = 1'b1;
      tick();
      EN_byteOut_get = 1'b0;
   endtask

   initial begin
      RST = 1'b0;
      byteIn_put = '0; EN_byteIn_put = 1'b0; EN_byteOut_get = 1'b0;
      msgToFeeder_rdy = 1'b0; msgFromFeeder_data = '0; msgFromFeeder_rdy = 1'b0;
      repeat (2) tick();

      // Reset state
      check("rst_rdy_in", RDY_byteIn_put, 1);
      check("rst_rdy_out", RDY_byteOut_get, 0);
      check("rst_up_en", msgToFeeder_en, 0);
      check("rst_byte_out", byteOut_get, 0);
      check("rst_up_data", msgToFeeder_data, 0);
      check("rst_err", errOverflow, 0);
      check("rst_words_up", wordsUp, 0);
      check("rst_words_down", wordsDown, 0);
      msgFromFeeder_rdy = 1'b1;
      #1 check("rst_dn_en_blocked", msgFromFeeder_en, 0);
      msgFromFeeder_rdy = 1'b0;
      RST = 1'b1;
      tick();

      // Single word upstream, no bypass through the FIFO
      msgToFeeder_rdy = 1'b1;
      put(8'h11); put(8'h22); put(8'h33);
      check("w1_none_yet", up_q.size(), 0);
      byteIn_put = 8'h44; EN_byteIn_put = 1'b1;
      #1 check("w1_no_bypass", msgToFeeder_en, 0);
      tick();
      EN_byteIn_put = 1'b0;
      check("w1_en", msgToFeeder_en, 1);
      check("w1_data", msgToFeeder_data, 32'h4433_2211);
      tick();
      check("w1_en_clear", msgToFeeder_en, 0);
      check("w1_count", up_q.size(), 1);
      check("w1_words_up", wordsUp, 1);
      check("w1_d2_words_up", d2_words_up, 1);

      // Backpressure: fill FIFO, fill packer, overflow, drain in order
      up_q.delete();
      msgToFeeder_rdy = 1'b0;
      for (int i = 0; i < 16; i++) put(8'(i + 1));
      check("bp_rdy_after16", RDY_byteIn_put, 1);
      check("bp_head", msgToFeeder_data, 32'h0403_0201);
      put(8'h11); put(8'h12);
      check("bp_rdy_cnt2", RDY_byteIn_put, 1);
      put(8'h13);
      check("bp_rdy_low", RDY_byteIn_put, 0);
      check("bp_err_before", errOverflow, 0);
      put(8'hEE);
      check("bp_err_set", errOverflow, 1);
      check("bp_no_push", up_q.size(), 0);
      msgToFeeder_rdy = 1'b1;
      repeat (6) tick();
      check("bp_drain_count", up_q.size(), 4);
      check("bp_drain0", up_q[0], 32'h0403_0201);
      check("bp_drain1", up_q[1], 32'h0807_0605);
      check("bp_drain2", up_q[2], 32'h0C0B_0A09);
      check("bp_drain3", up_q[3], 32'h100F_0E0D);
      check("bp_rdy_back", RDY_byteIn_put, 1);
      put(8'h14);
      repeat (2) tick();
      check("bp_tail_count", up_q.size(), 5);
      check("bp_tail_word", up_q[4], 32'h1413_1211);
      check("bp_words_up", wordsUp, 6);
      check("sat_d2_words_up", d2_words_up, 3);
      check("bp_err_sticky", errOverflow, 1);

      // Downstream serializer with a mid-word stall
      msgFromFeeder_data = 32'hDEAD_BEEF;
      msgFromFeeder_rdy  = 1'b1;
      #1 check("dn_en_idle", msgFromFeeder_en, 1);
      tick();
      check("dn_en_send", msgFromFeeder_en, 0);
      check("dn_rdy", RDY_byteOut_get, 1);
      check("dn_b0", byteOut_get, 8'hEF);
      get();
      check("dn_b1", byteOut_get, 8'hBE);
      get();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("dn_stall_b2", byteOut_get, 8'hAD);
      end
      check("dn_stall_en", msgFromFeeder_en, 0);
      get();
      check("dn_b3", byteOut_get, 8'hDE);
      check("dn_en_b3", msgFromFeeder_en, 0);
      get();
      check("dn_rdy_done", RDY_byteOut_get, 0);
      check("dn_en_again", msgFromFeeder_en, 1);
      msgFromFeeder_rdy = 1'b0;
      tick();
      check("dn_words_down", wordsDown, 1);
      check("dn_seen", dn_seen, 1);

      // Get while not ready is ignored
      get();
      check("dn_ign_rdy", RDY_byteOut_get, 0);
      check("dn_ign_byte", byteOut_get, 0);
      msgFromFeeder_data = 32'h5566_7788;
      msgFromFeeder_rdy  = 1'b1;
      tick();
      msgFromFeeder_rdy  = 1'b0;
      check("dn2_b0", byteOut_get, 8'h88);
      check("dn2_words_down", wordsDown, 2);

      // Reset mid-word discards partial bytes and the in-flight word
      put(8'hAA); put(8'hBB);
      RST = 1'b0;
      tick();
      check("mr_rdy_in", RDY_byteIn_put, 1);
      check("mr_rdy_out", RDY_byteOut_get, 0);
      check("mr_byte_out", byteOut_get, 0);
      check("mr_err", errOverflow, 0);
      check("mr_words_up", wordsUp, 0);
      check("mr_words_down", wordsDown, 0);
      check("mr_up_en", msgToFeeder_en, 0);
      RST = 1'b1;
      up_q.delete();
      put(8'h01); put(8'h02); put(8'h03); put(8'h04);
      repeat (2) tick();
      check("mr_count", up_q.size(), 1);
      check("mr_word", up_q[0], 32'h0403_0201);
      check("mr_err_after", errOverflow, 0);
      check("mr_words_up_after", wordsUp, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
